// File: rtl/fp_divider_32bit_iter.sv
// Sequential IEEE-754 single-precision divider, result = a / b.
// The mantissas go through a 26-step restoring division, one quotient bit per
// cycle, and the operation always takes the same number of cycles.
// Numeric policy: an exponent below 96 counts as zero, rounding is round-half-up,
// results that are too large saturate, results that are too small flush to zero.
// There is no NaN, Inf or denormal handling.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i; done_o pulses here after a completed op
// CALC  | one restoring-division step per cycle, 26 steps in total
// FIN   | normalise, round, resolve special cases, register outputs
module fp_divider_32bit_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        dz_o,
    output logic        ovf_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t       state_q;
    logic         s_q;
    logic [7:0]   ea_q;
    logic [7:0]   eb_q;
    logic [23:0]  mb_q;
    logic [25:0]  r_q;
    logic [25:0]  q_q;
    logic [4:0]   cnt_q;
    logic [31:0]  result_q;
    logic         done_q;
    logic         busy_q;
    logic         dz_q;
    logic         ovf_q;

    logic         ge;
    logic [25:0]  r_sub;
    logic [25:0]  r_d;
    logic [25:0]  q_d;

    logic [22:0]  m_raw;
    logic         rb;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_fin;
    logic [23:0]  m_rnd;
    logic [22:0]  m_fin;
    logic [31:0]  result_d;
    logic         dz_d;
    logic         ovf_d;

    // One restoring step: subtract the divisor when it fits, then shift left.
    // The remainder stays below 2*mb, so 26 bits never overflow.
    always_comb begin
        ge    = (r_q >= {2'b00, mb_q});
        r_sub = r_q - {2'b00, mb_q};
        r_d   = ge ? {r_sub[24:0], 1'b0} : {r_q[24:0], 1'b0};
        q_d   = {q_q[24:0], ge};
    end

    // Normalise the quotient (it lies in [2^24, 2^26)), round, pick the result.
    always_comb begin
        if (q_q[25]) begin
            m_raw  = q_q[24:2];
            rb     = q_q[1];
            e_norm = 10'(ea_q) - 10'(eb_q) + 10'sd127;
        end else begin
            m_raw  = q_q[23:1];
            rb     = q_q[0];
            e_norm = 10'(ea_q) - 10'(eb_q) + 10'sd126;
        end
        m_rnd = {1'b0, m_raw} + 24'(rb);
        m_fin = m_rnd[23] ? 23'd0 : m_rnd[22:0];
        e_fin = e_norm + (m_rnd[23] ? 10'sd1 : 10'sd0);

        dz_d  = (eb_q < 8'd96);
        ovf_d = 1'b0;
        if (ea_q < 8'd96) begin
            result_d = 32'h0000_0000;
        end else if (eb_q < 8'd96) begin
            result_d = {s_q, 8'hFE, 23'h7FFFFF};
        end else if (e_fin >= 10'sd255) begin
            result_d = {s_q, 8'hFE, 23'h7FFFFF};
            ovf_d    = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            result_d = 32'h0000_0000;
        end else begin
            result_d = {s_q, e_fin[7:0], m_fin};
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            s_q      <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            mb_q     <= 24'd0;
            r_q      <= 26'd0;
            q_q      <= 26'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        s_q     <= a_i[31] ^ b_i[31];
                        ea_q    <= a_i[30:23];
                        eb_q    <= b_i[30:23];
                        mb_q    <= {1'b1, b_i[22:0]};
                        r_q     <= {2'b01, a_i[22:0]};
                        q_q     <= 26'd0;
                        cnt_q   <= 5'd25;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (cnt_q == 5'd0) begin
                        state_q <= FIN;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                FIN: begin
                    result_q <= result_d;
                    dz_q     <= dz_d;
                    ovf_q    <= ovf_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;
    assign dz_o     = dz_q;
    assign ovf_o    = ovf_q;

endmodule
